// File: rtl/spi_word_receiver_if.sv
// spi_word_receiver_if
//   Bundles the serial link (mosi/cs/sclk) and the parallel word handshake
//   of spi_word_receiver.
//   slave  : receiver side (serial in, words out)
//   master : producer/consumer side (drives the serial link and rx_ready)
//   Signals:
//     mosi, cs (active low), sclk : SPI mode 0 link, asynchronous
//     rx_data, rx_valid, rx_ready  : word handshake
//     frame_start, frame_end       : one-cycle frame boundary strobes
//     frame_error                  : frame ended with a partial word
//     word_count                   : complete words in current/last frame
//     overrun                      : sticky, a completed word was dropped
interface spi_word_receiver_if #(
  parameter int DATA_W = 16
);
  logic              mosi;
  logic              cs;
  logic              sclk;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              frame_start;
  logic              frame_end;
  logic              frame_error;
  logic [7:0]        word_count;
  logic              overrun;

  modport slave (
    input  mosi, cs, sclk, rx_ready,
    output rx_data, rx_valid, frame_start, frame_end, frame_error,
           word_count, overrun
  );

  modport master (
    output mosi, cs, sclk, rx_ready,
    input  rx_data, rx_valid, frame_start, frame_end, frame_error,
           word_count, overrun
  );
endinterface

// File: rtl/spi_word_receiver.sv
// spi_word_receiver
//   SPI mode 0, MSB-first slave receiver. Oversamples mosi/cs/sclk on the
//   system clock and presents completed words through a valid/ready
//   handshake, with frame strobes, a partial-frame error and a sticky
//   overrun flag.
//   Ports:
//     MAX10_CLK1_50 : system clock
//     reset         : asynchronous, active-high reset
//     bus           : spi_word_receiver_if.slave (serial link + word handshake)
//   Parameters:
//     DATA_W        : bits per word, 8..32
//     FIFO_DEPTH    : output FIFO entries (power of 2, >= 2)
//   Build option:
//     SPI_RX_FIFO_EN defined   -> FIFO_DEPTH-entry output FIFO
//     SPI_RX_FIFO_EN undefined -> single holding register
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   WAIT_IDLE | after reset; wait for synchronized cs high (drops any
//             | frame already in progress)
//   IDLE      | between frames; cs falling edge starts a frame
//   SHIFT     | in a frame; sample mosi on sclk rise, cs rise ends frame
module spi_word_receiver #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               MAX10_CLK1_50,
  input  logic               reset,
  spi_word_receiver_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  // [0] first sync stage, [1] synchronized, [2] delayed copy for edge detect
  logic [2:0] cs_sync;
  logic [2:0] sclk_sync;
  logic [2:0] mosi_sync;

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      cs_sync   <= 3'b111;
      sclk_sync <= 3'b000;
      mosi_sync <= 3'b000;
    end else begin
      cs_sync   <= {cs_sync[1:0], bus.cs};
      sclk_sync <= {sclk_sync[1:0], bus.sclk};
      mosi_sync <= {mosi_sync[1:0], bus.mosi};
    end
  end

  logic cs_fall, cs_rise, sclk_rise, mosi_dly;
  assign cs_fall   = cs_sync[2] & ~cs_sync[1];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign mosi_dly  = mosi_sync[2];

  // The synchronizers come out of reset showing cs high regardless of the
  // pin; hold WAIT_IDLE until they have flushed so a low cs at reset
  // release is not mistaken for idle and then a falling edge.
  logic [1:0] settle_cnt;

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset)
      settle_cnt <= 2'd3;
    else if (settle_cnt != 2'd0)
      settle_cnt <= settle_cnt - 2'd1;
  end

  state_t state, state_nxt;

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset)
      state <= WAIT_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_IDLE: if (settle_cnt == 2'd0 && cs_sync[1]) state_nxt = IDLE;
      IDLE:      if (cs_fall) state_nxt = SHIFT;
      SHIFT:     if (cs_rise) state_nxt = IDLE;
      default:   state_nxt = WAIT_IDLE;
    endcase
  end

  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic             start_frame, shift_en, word_done, end_frame, err_nxt;

  // A coincident sclk rise is folded into bit_cnt_nxt before the partial
  // check, so a last bit arriving with cs rise still completes the word.
  always_comb begin
    start_frame = 1'b0;
    shift_en    = 1'b0;
    word_done   = 1'b0;
    end_frame   = 1'b0;
    err_nxt     = 1'b0;
    bit_cnt_nxt = bit_cnt;
    case (state)
      IDLE: start_frame = cs_fall;
      SHIFT: begin
        shift_en  = sclk_rise;
        word_done = sclk_rise && (bit_cnt == LAST_BIT);
        if (word_done)
          bit_cnt_nxt = '0;
        else if (shift_en)
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end_frame = cs_rise;
        err_nxt   = cs_rise && (bit_cnt_nxt != '0);
      end
      default: ;
    endcase
  end

  logic [DATA_W-2:0] shift_reg;
  logic [DATA_W-1:0] commit_word;
  logic              commit_q;
  logic [7:0]        word_cnt;
  logic              frame_start_q, frame_end_q, frame_error_q;

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      bit_cnt       <= '0;
      shift_reg     <= '0;
      commit_word   <= '0;
      commit_q      <= 1'b0;
      word_cnt      <= 8'd0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      frame_start_q <= start_frame;
      frame_end_q   <= end_frame;
      frame_error_q <= err_nxt;
      commit_q      <= word_done;
      bit_cnt       <= start_frame ? '0 : bit_cnt_nxt;
      if (shift_en)
        shift_reg <= {shift_reg[DATA_W-3:0], mosi_dly};
      if (word_done)
        commit_word <= {shift_reg, mosi_dly};
      if (start_frame)
        word_cnt <= 8'd0;
      else if (word_done && word_cnt != 8'hFF)
        word_cnt <= word_cnt + 8'd1;
    end
  end

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              overrun_q;

`ifdef SPI_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       fill;
  logic              full, pop, push;

  assign full = (fill == (AW+1)'(FIFO_DEPTH));
  assign pop  = (fill != '0) && bus.rx_ready;
  // A pop in the same cycle frees the slot, so push still succeeds when full.
  assign push = commit_q && (!full || pop);

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= commit_word;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      fill <= fill + (AW+1)'(push) - (AW+1)'(pop);
      if (commit_q && !push)
        overrun_q <= 1'b1;
    end
  end

  assign out_data  = mem[rd_ptr];
  assign out_valid = (fill != '0);
`else
  logic unused_fifo_depth;
  assign unused_fifo_depth = |FIFO_DEPTH;

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun_q <= 1'b0;
    end else if (commit_q) begin
      if (!out_valid || bus.rx_ready) begin
        out_data  <= commit_word;
        out_valid <= 1'b1;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (out_valid && bus.rx_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

  assign bus.rx_data     = out_data;
  assign bus.rx_valid    = out_valid;
  assign bus.overrun     = overrun_q;
  assign bus.word_count  = word_cnt;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.frame_error = frame_error_q;

endmodule

// File: tb/tb_spi_word_receiver.sv
// tb_spi_word_receiver
//   Directed SPI frames against spi_word_receiver. A word-level model
//   (bit accumulator + expected-word queue with the output capacity)
//   predicts delivered words, frame_error, word_count and overrun; a
//   negedge compare process checks the DUT against it, and the stimulus
//   adds literal checks on values and latencies.
module tb_spi_word_receiver;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 8;
`ifdef SPI_RX_FIFO_EN
  localparam int CAP = FIFO_DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  spi_word_receiver_if #(.DATA_W(DATA_W)) bus ();

  spi_word_receiver #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .MAX10_CLK1_50 (clk),
    .reset         (reset),
    .bus           (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [DATA_W-1:0] m_acc;
  int                m_bits;
  int                m_words;
  logic              m_ovr;
  logic              exp_err;
  int                exp_wc;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] rcv[$];
  int                fs_cnt = 0;

  function automatic logic [DATA_W-1:0] rcv_at(input int i);
    if (i < rcv.size()) return rcv[i];
    return '0;
  endfunction

  // ---------------- compare process ----------------
  logic              prev_hold = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("held_valid", bus.rx_valid, 1);
        check("held_data", bus.rx_data, prev_data);
      end
      if (bus.rx_valid && bus.rx_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rx_data: got unexpected word 0x%0h, expected no word", bus.rx_data);
        end else begin
          check("rx_data", bus.rx_data, exp_q.pop_front());
        end
        rcv.push_back(bus.rx_data);
      end
      if (bus.frame_end) begin
        check("frame_error", bus.frame_error, exp_err);
        check("word_count", bus.word_count, exp_wc);
        check("overrun", bus.overrun, m_ovr);
      end else if (bus.frame_error) begin
        check("frame_error_without_end", bus.frame_error, 0);
      end
      if (bus.frame_start) fs_cnt++;
      prev_hold = bus.rx_valid && !bus.rx_ready;
      prev_data = bus.rx_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #5;
    end
  endtask

  task automatic frame_begin();
    int lat;
    lat     = 0;
    m_bits  = 0;
    m_words = 0;
    bus.cs  = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (lat == 0 && bus.frame_start) lat = i;
      #4;
    end
    check("frame_start_latency", lat, 3);
  endtask

  task automatic send_bit(input logic b, input bit rise_only, output int lat, output bit committed);
    lat       = 0;
    committed = 1'b0;
    bus.mosi  = b;
    bus.sclk  = 1'b0;
    ticks(4);
    bus.sclk = 1'b1;
    m_acc = {m_acc[DATA_W-2:0], b};
    m_bits++;
    if (m_bits == DATA_W) begin
      if (exp_q.size() < CAP) exp_q.push_back(m_acc);
      else m_ovr = 1'b1;
      m_bits = 0;
      m_words++;
      committed = 1'b1;
    end
    if (!rise_only) begin
      for (int i = 0; i < 4; i++) begin
        @(posedge clk);
        #1;
        if (lat == 0 && bus.rx_valid) lat = i + 1;
        #4;
      end
    end
  endtask

  // tail < 0: normal end, tail 0: last sclk rise with cs rise, tail 1: cs one clock later
  task automatic send_bits(input logic [63:0] v, input int n, input int tail, output int first_lat);
    int l;
    bit c;
    first_lat = 0;
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(v[i], (i == 0) && (tail >= 0), l, c);
      if (c && first_lat == 0) first_lat = l;
    end
  endtask

  task automatic frame_finish(input int tail, output logic got_err, output int got_wc);
    int lat;
    lat     = 0;
    got_err = 1'b0;
    got_wc  = -1;
    exp_err = (m_bits != 0);
    exp_wc  = (m_words > 255) ? 255 : m_words;
    if (tail < 0) begin
      bus.sclk = 1'b0;
      ticks(4);
    end else if (tail == 1) begin
      ticks(1);
    end
    bus.cs = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (lat == 0 && bus.frame_end) begin
        lat     = i;
        got_err = bus.frame_error;
        got_wc  = int'(bus.word_count);
      end
      #4;
    end
    check("frame_end_latency", lat, 3);
    bus.sclk = 1'b0;
    ticks(4);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int   lat;
    int   wc;
    logic err;
    int   fs0;
    int   want;

    bus.cs       = 1'b1;
    bus.sclk     = 1'b0;
    bus.mosi     = 1'b0;
    bus.rx_ready = 1'b1;
    m_acc        = '0;
    m_bits       = 0;
    m_words      = 0;
    m_ovr        = 1'b0;
    exp_err      = 1'b0;
    exp_wc       = 0;
    ticks(3);

    check("reset_rx_valid", bus.rx_valid, 0);
    check("reset_rx_data", bus.rx_data, 0);
    check("reset_word_count", bus.word_count, 0);
    check("reset_overrun", bus.overrun, 0);
    check("reset_frame_start", bus.frame_start, 0);
    check("reset_frame_end", bus.frame_end, 0);
    check("reset_frame_error", bus.frame_error, 0);
    reset = 1'b0;
    ticks(8);

    // two full words, consumer always ready
    rcv.delete();
    frame_begin();
    send_bits(64'hA5C3_0F01, 32, -1, lat);
    check("rx_valid_latency", lat, 4);
    frame_finish(-1, err, wc);
    check("two_word_count", wc, 2);
    check("two_word_error", err, 0);
    check("two_word_n", rcv.size(), 2);
    check("two_word_0", rcv_at(0), 16'hA5C3);
    check("two_word_1", rcv_at(1), 16'h0F01);
    check("two_word_drained", bus.rx_valid, 0);

    // 20-bit frame: one word plus a 4-bit fragment
    rcv.delete();
    frame_begin();
    send_bits(64'h12345, 20, -1, lat);
    frame_finish(-1, err, wc);
    check("partial_count", wc, 1);
    check("partial_error", err, 1);
    check("partial_word", rcv_at(0), 16'h1234);
    check("partial_n", rcv.size(), 1);

    // three words while the consumer stalls
    rcv.delete();
    bus.rx_ready = 1'b0;
    frame_begin();
    send_bits(64'h1111_2222_3333, 48, -1, lat);
    frame_finish(-1, err, wc);
    check("stall_count", wc, 3);
`ifdef SPI_RX_FIFO_EN
    check("stall_overrun", bus.overrun, 0);
    want = 3;
`else
    check("stall_overrun", bus.overrun, 1);
    want = 1;
`endif
    check("stall_valid", bus.rx_valid, 1);
    check("stall_head", bus.rx_data, 16'h1111);
    bus.rx_ready = 1'b1;
    for (int i = 0; i < 40 && rcv.size() < want; i++) ticks(1);
    ticks(3);
    check("stall_drain_n", rcv.size(), want);
    check("stall_drain_0", rcv_at(0), 16'h1111);
`ifdef SPI_RX_FIFO_EN
    check("stall_drain_1", rcv_at(1), 16'h2222);
    check("stall_drain_2", rcv_at(2), 16'h3333);
`endif
    check("stall_empty", bus.rx_valid, 0);

    // reset after 7 bits with cs held low
    frame_begin();
    send_bits(64'h55, 7, -1, lat);
    reset    = 1'b1;
    bus.sclk = 1'b0;
    #1;
    check("midreset_rx_valid", bus.rx_valid, 0);
    check("midreset_rx_data", bus.rx_data, 0);
    check("midreset_word_count", bus.word_count, 0);
    check("midreset_overrun", bus.overrun, 0);
    exp_q.delete();
    m_ovr = 1'b0;
    ticks(3);
    reset = 1'b0;
    fs0 = fs_cnt;
    ticks(15);
    check("midreset_no_start", fs_cnt - fs0, 0);
    bus.cs = 1'b1;
    ticks(8);
    rcv.delete();
    frame_begin();
    send_bits(64'hBEEF, 16, -1, lat);
    frame_finish(-1, err, wc);
    check("after_reset_count", wc, 1);
    check("after_reset_error", err, 0);
    check("after_reset_word", rcv_at(0), 16'hBEEF);

    // last sclk rise one clock before cs rise
    rcv.delete();
    frame_begin();
    send_bits(64'h5A5A, 16, 1, lat);
    frame_finish(1, err, wc);
    ticks(4);
    check("near_count", wc, 1);
    check("near_error", err, 0);
    check("near_word", rcv_at(0), 16'h5A5A);

    // last sclk rise in the same clock as cs rise
    rcv.delete();
    frame_begin();
    send_bits(64'h1357_C3C3, 32, 0, lat);
    frame_finish(0, err, wc);
    ticks(4);
    check("aligned_count", wc, 2);
    check("aligned_error", err, 0);
    check("aligned_word_0", rcv_at(0), 16'h1357);
    check("aligned_word_1", rcv_at(1), 16'hC3C3);
    check("aligned_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/spi_word_receiver.md
# spi_word_receiver

Synchronous SPI slave receiver (mode 0, MSB first) that deserializes the `mosi`/`cs`/`sclk` stream produced by the fingerprint core's SPI output back into parallel words on the system clock. It sits on the consumer side of the link, either on the host board or looped back on the same FPGA for self-test, and presents words through a valid/ready handshake with frame-boundary strobes and error flags.

## Interface

- `DATA_W`, 16: bits per word; legal range 8–32.
- `FIFO_DEPTH`, 8: output FIFO entries; power of 2, at least 2. Used only when `SPI_RX_FIFO_EN` is defined.
- `MAX10_CLK1_50`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `mosi`  in  1  serial data, asynchronous to the system clock.
- `cs`  in  1  chip select, active low, asynchronous.
- `sclk`  in  1  serial clock, idle low, asynchronous.
- `rx_data`  out  DATA_W  received word, valid while `rx_valid` is high.
- `rx_valid`  out  1  word available.
- `rx_ready`  in  1  consumer accepts the word. A transfer occurs on any cycle where `rx_valid` and `rx_ready` are both high.
- `frame_start`  out  1  one-cycle pulse when a frame begins.
- `frame_end`  out  1  one-cycle pulse when a frame ends.
- `frame_error`  out  1  one-cycle pulse, coincident with `frame_end`, when the frame ended with a partial word.
- `word_count`  out  8  complete words received in the current or most recent frame; saturates at 255.
- `overrun`  out  1  sticky flag: a completed word was dropped. Cleared only by `reset`.

## Operation

- `mosi`, `cs` and `sclk` each pass through a 2-FF synchronizer. Synchronizer reset values: `cs` = 1, `sclk` = 0, `mosi` = 0.
- A third register on each synchronized signal feeds the edge detectors.
- FSM states:
  - WAIT_IDLE, entered on reset. Moves to IDLE once the synchronized `cs` is high. A frame already in progress at reset release is therefore ignored.
  - IDLE. On a synchronized `cs` falling edge: go to SHIFT, pulse `frame_start`, clear `bit_cnt` and `word_count`.
  - SHIFT. On each `sclk` rising edge, shift the delayed synchronized `mosi` into the LSB of the shift register and increment `bit_cnt`. When `bit_cnt` reaches DATA_W−1 on an edge, the completed word (including this bit) is committed to the output stage, `bit_cnt` wraps to 0, and `word_count` increments. On a `cs` rising edge: pulse `frame_end`, pulse `frame_error` if `bit_cnt` ≠ 0, discard the partial word, go to IDLE.
- If an `sclk` rising edge and a `cs` rising edge are detected in the same cycle, the bit is shifted (and any resulting word committed) before the frame ends.
- `sclk` edges seen in IDLE or WAIT_IDLE are ignored.
- Output stage without FIFO: one holding register.
  - A commit while the register is empty loads it.
  - A commit while `rx_valid` is high and `rx_ready` is high transfers the old word and loads the new one in the same cycle; no error.
  - A commit while `rx_valid` is high and `rx_ready` is low drops the new word and sets `overrun`.
- All outputs reset to 0.

## Timing

- Input constraint: `sclk` high time and low time are each at least 3 system clocks, so the maximum `sclk` is about 8 MHz.
- `mosi` must be stable from 1 clock before the `sclk` rising edge until 1 clock after it.
- Latency:
  - From the last `sclk` rising edge at the pin to `rx_valid` high: 4 clocks.
  - From the `cs` falling edge at the pin to `frame_start`: 3 clocks.
  - From the `cs` rising edge at the pin to `frame_end`: 3 clocks.
- `rx_data` stays stable while `rx_valid` is high and `rx_ready` is low.
- `rx_valid` drops on the cycle after a transfer unless a new word is loaded on that same cycle.
- Reset asserted mid-frame clears all state within the same cycle, asynchronously. The receiver then sits in WAIT_IDLE.

## Configuration

- `SPI_RX_FIFO_EN` defined: a FIFO of FIFO_DEPTH entries replaces the holding register.
  - `rx_valid` means the FIFO is not empty; `rx_data` is the head entry.
  - `overrun` is set only when a commit arrives while the FIFO is full and no pop occurs in that cycle.
  - When full, a simultaneous push and pop both succeed.
- `SPI_RX_FIFO_EN` undefined: single holding register as described under Operation; FIFO_DEPTH is ignored.

## Test plan

- Frame of 2 words, 0xA5C3 then 0x0F01, with `rx_ready` held at 1 -> two `rx_valid` pulses carrying those values, `word_count` = 2, `frame_end` high, `frame_error` low.
- Frame of 20 bits -> one word delivered, `frame_error` pulses together with `frame_end`, `word_count` = 1.
- 3 words with `rx_ready` = 0, no FIFO -> first word held, `overrun` = 1. With `SPI_RX_FIFO_EN` -> all 3 words drain in order after `rx_ready` rises, `overrun` = 0.
- Reset asserted after 7 bits of a frame with `cs` kept low -> outputs 0, no `frame_start` until `cs` goes high and then low again; the next full frame is received correctly.
- Last `sclk` rising edge and `cs` rise 1 clock apart, and then aligned in the same clock -> the word is committed and `frame_error` stays low in both cases.
